// File: rtl/note_seq_pkg.sv
// note_seq_pkg: shared constants and helpers for the note sequencer.
//   - lane direction encoding
//   - chart word field slicing (lane mask / delay)
//   - extraction of one lane's value from a packed per-lane parameter
package note_seq_pkg;

    localparam logic DIR_ASC  = 1'b0;
    localparam logic DIR_DESC = 1'b1;

    // Widest packed per-lane parameter and chart word the helpers accept.
    localparam int PACK_W = 1024;
    localparam int WORD_W = 64;

    // Lane mask sits above the delay field in a chart word.
    function automatic logic [WORD_W-1:0] chart_mask(input logic [WORD_W-1:0] word,
                                                     input int dly_w);
        return word >> dly_w;
    endfunction

    function automatic logic [WORD_W-1:0] chart_delay(input logic [WORD_W-1:0] word,
                                                      input int dly_w);
        return word & ((64'd1 << dly_w) - 64'd1);
    endfunction

    // Lane 'lane' occupies bits [lane*pos_w +: pos_w] of a packed start/end parameter.
    function automatic logic [31:0] lane_field(input logic [PACK_W-1:0] packed_v,
                                               input int lane,
                                               input int pos_w);
        logic [PACK_W-1:0] sh;
        sh = packed_v >> (lane * pos_w);
        return sh[31:0] & ((32'd1 << pos_w) - 32'd1);
    endfunction

endpackage

// File: rtl/note_lane_queue.sv
// note_lane_queue: one lane's circular queue of live notes.
//   clk, clr     : clock and synchronous clear (reset or not running)
//   tick         : frame strobe; moves notes and runs the end-of-lane check
//   push         : spawn a note at START_POS into the tail
//   pop_hit      : remove the oldest note (ignored when empty)
//   pos, vld     : per-slot position and valid, registered
//   full         : lane holds SLOTS notes
//   miss, ovf    : one-cycle pulses for an end-of-lane retire / dropped spawn
module note_lane_queue
    import note_seq_pkg::*;
#(
    parameter int               SLOTS     = 4,
    parameter int               POS_W     = 10,
    parameter int               STEP      = 2,
    parameter logic             DIR       = DIR_ASC,
    parameter logic [POS_W-1:0] START_POS = '0,
    parameter logic [POS_W-1:0] END_POS   = '0
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   tick,
    input  logic                   push,
    input  logic                   pop_hit,
    output logic [SLOTS*POS_W-1:0] pos,
    output logic [SLOTS-1:0]       vld,
    output logic                   full,
    output logic                   miss,
    output logic                   ovf
);

    localparam int               PTR_W  = $clog2(SLOTS);
    localparam int               CNT_W  = PTR_W + 1;
    localparam logic [POS_W-1:0] STEP_V = POS_W'(STEP);
    localparam logic [POS_W-1:0] MAX_V  = {POS_W{1'b1}};

    logic [POS_W-1:0] pos_r [SLOTS];
    logic [POS_W-1:0] pos_n [SLOTS];
    logic [SLOTS-1:0] vld_r, vld_n;
    logic [PTR_W-1:0] head_r, head_n, tail_r, tail_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic             miss_r, ovf_r;
    logic             hit_pop_s, miss_pop_s, pop_s, push_ok_s, ovf_s, reached_s, full_s;
    logic [POS_W-1:0] head_pos_s;

    // Saturating move toward the lane end; positions never wrap.
    function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] p);
        if (DIR == DIR_DESC) begin
            return (p < STEP_V) ? '0 : p - STEP_V;
        end else begin
            return (p > MAX_V - STEP_V) ? MAX_V : p + STEP_V;
        end
    endfunction

    // Pop/spawn arbitration and next slot contents: move, then pop clear, then spawn write.
    always_comb begin
        full_s     = (cnt_r == CNT_W'(SLOTS));
        head_pos_s = pos_r[head_r];
        if (DIR == DIR_DESC) begin
            reached_s = (head_pos_s <= END_POS);
        end else begin
            reached_s = (head_pos_s >= END_POS);
        end
        hit_pop_s  = pop_hit && (cnt_r != '0);
        // A hit on the same head wins over its miss.
        miss_pop_s = tick && (cnt_r != '0) && vld_r[head_r] && reached_s && !hit_pop_s;
        pop_s      = hit_pop_s || miss_pop_s;
        // A pop in the same cycle frees a slot for a spawn into a full lane.
        push_ok_s  = push && (!full_s || pop_s);
        ovf_s      = push && full_s && !pop_s;

        vld_n = vld_r;
        for (int j = 0; j < SLOTS; j++) begin
            if (tick && vld_r[j]) begin
                pos_n[j] = step_pos(pos_r[j]);
            end else begin
                pos_n[j] = pos_r[j];
            end
        end
        if (pop_s) begin
            vld_n[head_r] = 1'b0;
            pos_n[head_r] = '0;
        end else begin
            vld_n[head_r] = vld_n[head_r];
        end
        if (push_ok_s) begin
            vld_n[tail_r] = 1'b1;
            pos_n[tail_r] = START_POS;
        end else begin
            vld_n[tail_r] = vld_n[tail_r];
        end

        head_n = head_r + PTR_W'(pop_s);
        tail_n = tail_r + PTR_W'(push_ok_s);
        cnt_n  = cnt_r + CNT_W'(push_ok_s) - CNT_W'(pop_s);
    end

    // Queue state and event pulse registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int j = 0; j < SLOTS; j++) begin
                pos_r[j] <= '0;
            end
            vld_r  <= '0;
            head_r <= '0;
            tail_r <= '0;
            cnt_r  <= '0;
            miss_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            for (int j = 0; j < SLOTS; j++) begin
                pos_r[j] <= pos_n[j];
            end
            vld_r  <= vld_n;
            head_r <= head_n;
            tail_r <= tail_n;
            cnt_r  <= cnt_n;
            miss_r <= miss_pop_s;
            ovf_r  <= ovf_s;
        end
    end

    for (genvar j = 0; j < SLOTS; j++) begin : g_flat
        assign pos[j*POS_W +: POS_W] = pos_r[j];
    end
    assign vld  = vld_r;
    assign full = (cnt_r == CNT_W'(SLOTS));
    assign miss = miss_r;
    assign ovf  = ovf_r;

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: chart-driven note scheduler.
//   clk, rst, run : clock, synchronous active-high reset, play enable (low = held in reset)
//   tick          : frame strobe; advances the chart walk and moves notes
//   hit           : per-lane request to remove the oldest note
//   chart_addr    : chart ROM address; chart_data is its combinational read {lane_mask, delay}
//   note_pos/vld  : flattened slot state, slot j of lane i at index i*SLOTS+j
//   miss, ovf     : per-lane one-cycle pulses
//   chart_done    : last chart word consumed
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int                     LANES      = 8,
    parameter int                     SLOTS      = 4,
    parameter int                     POS_W      = 10,
    parameter int                     STEP       = 2,
    parameter int                     DLY_W      = 10,
    parameter int                     ADDR_W     = 8,
    parameter int                     CHART_LEN  = 144,
    parameter logic [LANES-1:0]       LANE_DIR   = '0,
    parameter logic [LANES*POS_W-1:0] LANE_START = '0,
    parameter logic [LANES*POS_W-1:0] LANE_END   = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         run,
    input  logic                         tick,
    input  logic [LANES-1:0]             hit,
    output logic [ADDR_W-1:0]            chart_addr,
    input  logic [LANES+DLY_W-1:0]       chart_data,
    output logic [LANES*SLOTS*POS_W-1:0] note_pos,
    output logic [LANES*SLOTS-1:0]       note_vld,
    output logic [LANES-1:0]             miss,
    output logic [LANES-1:0]             ovf,
    output logic                         chart_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CHART_LEN - 1);

    logic [ADDR_W-1:0] addr_r;
    logic [DLY_W-1:0]  dly_r;
    logic              done_r;
    logic              clr_s, fire_s;
    logic [63:0]       word_s, mask_s, delay_s;
    logic [LANES-1:0]  push_s, full_s;

    assign clr_s   = rst || !run;
    assign word_s  = 64'(chart_data);
    assign mask_s  = chart_mask(word_s, DLY_W);
    assign delay_s = chart_delay(word_s, DLY_W);
    // A chart word is consumed on a tick once its predecessor's delay has run out.
    assign fire_s  = tick && (dly_r == '0) && !done_r;
    assign push_s  = fire_s ? mask_s[LANES-1:0] : '0;

    // Chart walk: address, delay countdown and end-of-chart flag.
    always_ff @(posedge clk) begin
        if (clr_s) begin
            addr_r <= '0;
            dly_r  <= '0;
            done_r <= 1'b0;
        end else if (fire_s) begin
            dly_r <= delay_s[DLY_W-1:0];
            if (addr_r == LAST_ADDR) begin
                done_r <= 1'b1;
            end else begin
                addr_r <= addr_r + ADDR_W'(1);
            end
        end else if (tick && (dly_r != '0)) begin
            dly_r <= dly_r - DLY_W'(1);
        end else begin
            dly_r <= dly_r;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam logic [31:0] START_V = lane_field(PACK_W'(LANE_START), i, POS_W);
        localparam logic [31:0] END_V   = lane_field(PACK_W'(LANE_END), i, POS_W);

        note_lane_queue #(
            .SLOTS     (SLOTS),
            .POS_W     (POS_W),
            .STEP      (STEP),
            .DIR       (LANE_DIR[i]),
            .START_POS (START_V[POS_W-1:0]),
            .END_POS   (END_V[POS_W-1:0])
        ) u_lane (
            .clk     (clk),
            .clr     (clr_s),
            .tick    (tick),
            .push    (push_s[i]),
            .pop_hit (hit[i]),
            .pos     (note_pos[i*SLOTS*POS_W +: SLOTS*POS_W]),
            .vld     (note_vld[i*SLOTS +: SLOTS]),
            .full    (full_s[i]),
            .miss    (miss[i]),
            .ovf     (ovf[i])
        );
    end

    assign chart_addr = addr_r;
    assign chart_done = done_r;

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed self-checking bench for note_sequencer.
// Lanes: 0 and 1 ascend 0->20, lane 2 ascends 0->1000, lane 3 descends 100->80.
module tb_note_sequencer;

    localparam int LANES = 4;
    localparam int SLOTS = 4;
    localparam int POS_W = 10;
    localparam int DLY_W = 10;
    localparam int ADDR_W = 8;
    localparam int W = LANES + DLY_W;
    localparam logic [LANES-1:0]       DIR_P   = 4'b1000;
    localparam logic [LANES*POS_W-1:0] START_P = {10'd100, 10'd0, 10'd0, 10'd0};
    localparam logic [LANES*POS_W-1:0] END_P   = {10'd80, 10'd1000, 10'd20, 10'd20};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b1;
    logic run3 = 1'b0;
    logic tick = 1'b0;
    logic [LANES-1:0] hit = '0;

    logic [ADDR_W-1:0] chart_addr, chart_addr3;
    logic [W-1:0] chart_data, chart_data3;
    logic [LANES*SLOTS*POS_W-1:0] note_pos, note_pos3;
    logic [LANES*SLOTS-1:0] note_vld, note_vld3;
    logic [LANES-1:0] miss, miss3, ovf, ovf3;
    logic chart_done, chart_done3;

    logic [W-1:0] rom [256];
    logic [W-1:0] rom3 [256];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign chart_data  = rom[chart_addr];
    assign chart_data3 = rom3[chart_addr3];

    note_sequencer #(
        .LANES(LANES), .SLOTS(SLOTS), .POS_W(POS_W), .STEP(2), .DLY_W(DLY_W),
        .ADDR_W(ADDR_W), .CHART_LEN(16), .LANE_DIR(DIR_P),
        .LANE_START(START_P), .LANE_END(END_P)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .tick(tick), .hit(hit),
        .chart_addr(chart_addr), .chart_data(chart_data),
        .note_pos(note_pos), .note_vld(note_vld),
        .miss(miss), .ovf(ovf), .chart_done(chart_done)
    );

    note_sequencer #(
        .LANES(LANES), .SLOTS(SLOTS), .POS_W(POS_W), .STEP(2), .DLY_W(DLY_W),
        .ADDR_W(ADDR_W), .CHART_LEN(3), .LANE_DIR(DIR_P),
        .LANE_START(START_P), .LANE_END(END_P)
    ) dut3 (
        .clk(clk), .rst(rst), .run(run3), .tick(tick), .hit(hit),
        .chart_addr(chart_addr3), .chart_data(chart_data3),
        .note_pos(note_pos3), .note_vld(note_vld3),
        .miss(miss3), .ovf(ovf3), .chart_done(chart_done3)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] get_pos(input int l, input int s);
        return note_pos[(l*SLOTS+s)*POS_W +: POS_W];
    endfunction

    task automatic clear_rom();
        for (int k = 0; k < 256; k++) begin
            rom[k] = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic do_tick(input logic [LANES-1:0] h);
        @(negedge clk) begin tick = 1'b1; hit = h; end
        @(negedge clk) begin tick = 1'b0; hit = '0; end
    endtask

    task automatic do_hit(input logic [LANES-1:0] h);
        @(negedge clk) hit = h;
        @(negedge clk) hit = '0;
    endtask

    initial begin
        clear_rom();
        for (int k = 0; k < 256; k++) begin
            rom3[k] = '0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_addr", 32'(chart_addr), 32'd0);
        check_eq("rst_vld", 32'(note_vld), 32'd0);
        check_eq("rst_pos_nz", 32'(note_pos != '0), 32'd0);
        check_eq("rst_miss_ovf", {24'd0, miss, ovf}, 32'd0);
        check_eq("rst_done", 32'(chart_done), 32'd0);

        // Single note travels lane 0 from 0 to 20 and misses
        rom[0] = {4'b0001, 10'd0};
        rom[1] = {4'b0000, 10'd1023};
        rst = 1'b0;
        do_tick('0);
        check_eq("spawn_vld", 32'(note_vld), 32'h0001);
        check_eq("spawn_pos", 32'(get_pos(0, 0)), 32'd0);
        check_eq("spawn_addr", 32'(chart_addr), 32'd1);
        do_tick('0);
        check_eq("move1_pos", 32'(get_pos(0, 0)), 32'd2);
        for (int k = 0; k < 9; k++) begin
            do_tick('0);
        end
        check_eq("end_pos", 32'(get_pos(0, 0)), 32'd20);
        check_eq("end_nomiss", 32'(miss), 32'd0);
        do_tick('0);
        check_eq("miss_pulse", 32'(miss), 32'h1);
        check_eq("miss_vld", 32'(note_vld), 32'd0);
        @(negedge clk);
        check_eq("miss_one_cycle", 32'(miss), 32'd0);

        // Two lanes spawn together; next word consumed on the fourth tick after
        clear_rom();
        rom[0] = {4'b0011, 10'd3};
        rom[1] = {4'b0100, 10'd1023};
        do_reset();
        do_tick('0);
        check_eq("dual_vld", 32'(note_vld), 32'h0011);
        repeat (3) do_tick('0);
        check_eq("dly_hold_vld", 32'(note_vld), 32'h0011);
        check_eq("dly_hold_addr", 32'(chart_addr), 32'd1);
        do_tick('0);
        check_eq("dly_next_vld", 32'(note_vld), 32'h0111);
        check_eq("dly_next_addr", 32'(chart_addr), 32'd2);
        check_eq("dly_lane0_pos", 32'(get_pos(0, 0)), 32'd8);

        // Overflow in lane 2, then pop+spawn in a full lane
        clear_rom();
        for (int k = 0; k < 6; k++) begin
            rom[k] = {4'b0100, 10'd0};
        end
        rom[6] = {4'b0000, 10'd1023};
        do_reset();
        repeat (4) do_tick('0);
        check_eq("fill_vld", 32'(note_vld[11:8]), 32'hF);
        check_eq("fill_noovf", 32'(ovf), 32'd0);
        do_tick('0);
        check_eq("ovf_pulse", 32'(ovf), 32'h4);
        check_eq("ovf_vld", 32'(note_vld[11:8]), 32'hF);
        check_eq("ovf_head_pos", 32'(get_pos(2, 0)), 32'd8);
        @(negedge clk);
        check_eq("ovf_one_cycle", 32'(ovf), 32'd0);
        do_tick(4'b0100);
        check_eq("popspawn_noovf", 32'(ovf), 32'd0);
        check_eq("popspawn_vld", 32'(note_vld[11:8]), 32'hF);
        check_eq("popspawn_new", 32'(get_pos(2, 0)), 32'd0);
        check_eq("popspawn_old", 32'(get_pos(2, 1)), 32'd8);
        do_hit(4'b1000);
        check_eq("hit_empty_vld", 32'(note_vld), 32'h0F00);
        do_hit(4'b0100);
        check_eq("hit_pop_vld", 32'(note_vld[11:8]), 32'hD);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check_eq("midrst_addr", 32'(chart_addr), 32'd0);
        check_eq("midrst_vld", 32'(note_vld), 32'd0);

        // Hit coincides with a descending miss in lane 3; lane 1 misses normally
        clear_rom();
        rom[0] = {4'b1010, 10'd0};
        rom[1] = {4'b0000, 10'd1023};
        do_reset();
        repeat (11) do_tick('0);
        check_eq("desc_pos", 32'(get_pos(3, 0)), 32'd80);
        do_tick(4'b1000);
        check_eq("hitmiss_miss", 32'(miss), 32'h2);
        check_eq("hitmiss_vld", 32'(note_vld), 32'd0);

        // Short chart: end-of-chart behaviour and run deassert
        rom3[0] = {4'b0001, 10'd0};
        rom3[1] = {4'b0010, 10'd0};
        rom3[2] = {4'b0100, 10'd0};
        check_eq("run_low_addr", 32'(chart_addr3), 32'd0);
        @(negedge clk) run3 = 1'b1;
        repeat (2) do_tick('0);
        check_eq("pre_done", 32'(chart_done3), 32'd0);
        do_tick('0);
        check_eq("done_set", 32'(chart_done3), 32'd1);
        check_eq("done_addr", 32'(chart_addr3), 32'd2);
        check_eq("done_vld", 32'(note_vld3), 32'h0111);
        do_tick('0);
        check_eq("done_nospawn", 32'(note_vld3), 32'h0111);
        check_eq("done_addr_hold", 32'(chart_addr3), 32'd2);
        @(negedge clk) run3 = 1'b0;
        @(negedge clk);
        check_eq("runlow_addr", 32'(chart_addr3), 32'd0);
        check_eq("runlow_vld", 32'(note_vld3), 32'd0);
        check_eq("runlow_done", 32'(chart_done3), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
